// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: parametrised pipeline backbone with per-stage valid bits,
// stall (hold 0..k and put a bubble behind), flush (kill 0..f and put a bubble
// behind), halt/drain, and saturating retire/bubble counters.

// One pipeline register with its valid bit. The parent decides which action
// applies this cycle. kill beats hold, hold beats bubble, and bubble beats advance.
module pipe_ctrl_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kill,
  input  logic              hold,
  input  logic              bub,
  input  logic              ld,
  input  logic              nxt_vld,
  input  logic [DATA_W-1:0] nxt_dat,
  output logic              vld,
  output logic [DATA_W-1:0] dat
);

  // Stage register: kill clears payload, hold freezes, bubble drops valid only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (kill) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (hold) begin
      vld <= vld;
      dat <= dat;
    end else if (bub) begin
      vld <= 1'b0;
    end else begin
      vld <= nxt_vld;
      if (ld) dat <= nxt_dat;
    end
  end

endmodule

module pipe_ctrl_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     stall_en,
  input  logic [IDX_W-1:0]         stall_idx,
  input  logic                     flush_en,
  input  logic [IDX_W-1:0]         flush_idx,
  input  logic                     halt,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     drained,
  output logic [CNT_W-1:0]         retired_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(STAGES-1);

  logic [IDX_W-1:0] k, f;
  logic             accept;
  logic             retire_ev, bubble_ev;

  // Entry i feeds stage i; entry i+1 is stage i's register. Entry 0 is the input port.
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][DATA_W-1:0] dat_pipe;

  assign k        = (stall_idx > LAST) ? LAST : stall_idx;
  assign f        = (flush_idx > LAST) ? LAST : flush_idx;
  assign in_ready = !halt && !stall_en && !flush_en;
  assign accept   = in_valid && in_ready;

  assign vld_pipe[0] = accept;
  assign dat_pipe[0] = in_data;

  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_stg
      logic kill, hold, bub, ld;

      assign kill = flush_en && (IDX_W'(i) <= f);
      assign hold = stall_en && (IDX_W'(i) <= k);

      // Compare against i-1 rather than k+1/f+1 so a clamp at the top index
      // cannot wrap around and bubble stage 0.
      if (i == 0) begin : g_head
        assign bub = 1'b0;
        assign ld  = accept;
      end else begin : g_body
        assign bub = (stall_en && (IDX_W'(i-1) == k)) ||
                     (flush_en && (IDX_W'(i-1) == f));
        assign ld  = 1'b1;
      end

      pipe_ctrl_stage #(.DATA_W(DATA_W)) u_stg (
        .clk     (clk),
        .reset   (reset),
        .kill    (kill),
        .hold    (hold),
        .bub     (bub),
        .ld      (ld),
        .nxt_vld (vld_pipe[i]),
        .nxt_dat (dat_pipe[i]),
        .vld     (vld_pipe[i+1]),
        .dat     (dat_pipe[i+1])
      );

      assign stage_valid[i]                   = vld_pipe[i+1];
      assign stage_data[i*DATA_W +: DATA_W]   = dat_pipe[i+1];
    end
  endgenerate

  assign out_valid = vld_pipe[STAGES];
  assign out_data  = dat_pipe[STAGES];
  assign drained   = halt && (stage_valid == '0);

  // A stall that holds the last stage keeps its payload, so that payload is not retired yet.
  assign retire_ev = out_valid && !(stall_en && (k == LAST));
  assign bubble_ev = stall_en && (k != LAST);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (retire_ev && !(&retired_cnt)) retired_cnt <= retired_cnt + CNT_W'(1);
      if (bubble_ev && !(&bubble_cnt))  bubble_cnt  <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain: directed scenarios with literal expectations and
// a per-cycle comparison against an array-based model. A second instance with
// 4-bit counters exercises counter saturation.
module tb_pipe_ctrl_chain;

  localparam int DW = 32;
  localparam int ST = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          stall_en = 1'b0;
  logic [IW-1:0] stall_idx = '0;
  logic          flush_en = 1'b0;
  logic [IW-1:0] flush_idx = '0;
  logic          halt = 1'b0;

  logic             in_ready, out_valid, drained;
  logic [ST-1:0]    stage_valid;
  logic [ST*DW-1:0] stage_data;
  logic [DW-1:0]    out_data;
  logic [31:0]      retired_cnt, bubble_cnt;

  logic             s_in_ready, s_out_valid, s_drained;
  logic [ST-1:0]    s_stage_valid;
  logic [ST*DW-1:0] s_stage_data;
  logic [DW-1:0]    s_out_data;
  logic [3:0]       s_retired_cnt, s_bubble_cnt;

  pipe_ctrl_chain #(.DATA_W(DW), .STAGES(ST), .IDX_W(IW), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall_en(stall_en), .stall_idx(stall_idx),
    .flush_en(flush_en), .flush_idx(flush_idx), .halt(halt),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data), .drained(drained),
    .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_ctrl_chain #(.DATA_W(DW), .STAGES(ST), .IDX_W(IW), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .stall_en(stall_en), .stall_idx(stall_idx),
    .flush_en(flush_en), .flush_idx(flush_idx), .halt(halt),
    .stage_valid(s_stage_valid), .stage_data(s_stage_data),
    .out_valid(s_out_valid), .out_data(s_out_data), .drained(s_drained),
    .retired_cnt(s_retired_cnt), .bubble_cnt(s_bubble_cnt)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: pipe contents as plain arrays, counters as unbounded integers.
  logic        mv[ST] = '{default: 1'b0};
  logic [31:0] md[ST] = '{default: 32'h0};
  int unsigned mret = 0;
  int unsigned mbub = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ST; i++) begin mv[i] = 1'b0; md[i] = '0; end
      mret = 0;
      mbub = 0;
    end else begin : step
      logic        ov[ST];
      logic [31:0] od[ST];
      int kk, ff;
      logic acc;
      kk  = (int'(stall_idx) > ST-1) ? ST-1 : int'(stall_idx);
      ff  = (int'(flush_idx) > ST-1) ? ST-1 : int'(flush_idx);
      acc = in_valid && !halt && !stall_en && !flush_en;
      if (mv[ST-1] && !(stall_en && kk == ST-1)) mret++;
      if (stall_en && kk < ST-1) mbub++;
      ov = mv;
      od = md;
      for (int i = 0; i < ST; i++) begin
        if (flush_en && i <= ff) begin mv[i] = 1'b0; md[i] = '0; end
        else if (stall_en && i <= kk) begin mv[i] = ov[i]; md[i] = od[i]; end
        else if ((stall_en && i == kk+1) || (flush_en && i == ff+1)) mv[i] = 1'b0;
        else if (i == 0) begin mv[0] = acc; if (acc) md[0] = in_data; end
        else begin mv[i] = ov[i-1]; md[i] = od[i-1]; end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      logic anyv;
      anyv = 1'b0;
      for (int i = 0; i < ST; i++) begin
        anyv = anyv | mv[i];
        chk($sformatf("valid%0d", i), 64'(stage_valid[i]), 64'(mv[i]));
        chk($sformatf("data%0d", i), 64'(stage_data[i*DW +: DW]), 64'(md[i]));
      end
      chk("out_valid", 64'(out_valid), 64'(mv[ST-1]));
      chk("out_data", 64'(out_data), 64'(md[ST-1]));
      chk("in_ready", 64'(in_ready), 64'(!halt && !stall_en && !flush_en));
      chk("drained", 64'(drained), 64'(halt && !anyv));
      chk("retired", 64'(retired_cnt), 64'(mret));
      chk("bubble", 64'(bubble_cnt), 64'(mbub));
      chk("s_retired", 64'(s_retired_cnt), 64'((mret > 15) ? 15 : mret));
      chk("s_bubble", 64'(s_bubble_cnt), 64'((mbub > 15) ? 15 : mbub));
      chk("s_valid", 64'(s_stage_valid), 64'(stage_valid));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    logic [31:0] v[4];
    v = '{a, b, c, d};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_data = v[i]; tick(); end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  localparam logic [31:0] A = 32'ha1, B = 32'hb2, C = 32'hc3, D = 32'hd4;

  function automatic logic [31:0] sd(input int i);
    return stage_data[i*DW +: DW];
  endfunction

  initial begin
    logic [31:0] seq[5];
    seq = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    #12 reset = 1'b1;
    #1;
    chk("rst_valid", 64'(stage_valid), 64'h0);
    chk("rst_ret", 64'(retired_cnt), 64'h0);
    chk("rst_bub", 64'(bubble_cnt), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);

    // Stream: first output after the 4th edge, then back-to-back.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = seq[i];
      tick();
      if (i == 2) chk("stream_lat3", 64'(out_valid), 64'h0);
      if (i == 3) begin
        chk("stream_lat4", 64'(out_valid), 64'h1);
        chk("stream_d0", 64'(out_data), 64'h11);
      end
    end
    in_valid = 1'b0;
    chk("stream_d1", 64'(out_data), 64'h22);
    for (int i = 0; i < 4; i++) tick();
    chk("stream_empty", 64'(stage_valid), 64'h0);
    chk("stream_ret", 64'(retired_cnt), 64'd5);

    // Stall k=1 with pipe D,C,B,A.
    fill(A, B, C, D);
    stall_en = 1'b1; stall_idx = 3'd1;
    #1 chk("stall_ready", 64'(in_ready), 64'h0);
    tick();
    stall_en = 1'b0; stall_idx = '0;
    chk("stall_valid", 64'(stage_valid), 64'b1011);
    chk("stall_s0", 64'(sd(0)), 64'(D));
    chk("stall_s1", 64'(sd(1)), 64'(C));
    chk("stall_s3", 64'(sd(3)), 64'(B));
    chk("stall_ret", 64'(retired_cnt), 64'd6);
    chk("stall_bub", 64'(bubble_cnt), 64'd1);

    // Flush f=1.
    fill(A, B, C, D);
    flush_en = 1'b1; flush_idx = 3'd1;
    tick();
    flush_en = 1'b0; flush_idx = '0;
    chk("flush_valid", 64'(stage_valid), 64'b1000);
    chk("flush_s3", 64'(sd(3)), 64'(B));
    chk("flush_s0", 64'(sd(0)), 64'h0);
    chk("flush_ret", 64'(retired_cnt), 64'd10);

    // Flush f=0 combined with stall k=2.
    fill(A, B, C, D);
    flush_en = 1'b1; flush_idx = 3'd0;
    stall_en = 1'b1; stall_idx = 3'd2;
    tick();
    flush_en = 1'b0; stall_en = 1'b0; stall_idx = '0;
    chk("comb_valid", 64'(stage_valid), 64'b0110);
    chk("comb_s1", 64'(sd(1)), 64'(C));
    chk("comb_s2", 64'(sd(2)), 64'(B));
    chk("comb_bub", 64'(bubble_cnt), 64'd2);
    chk("comb_ret", 64'(retired_cnt), 64'd12);

    // Halt drains A,B,C,D while refusing input.
    fill(A, B, C, D);
    chk("halt_pre_ret", 64'(retired_cnt), 64'd14);
    halt = 1'b1; in_valid = 1'b1; in_data = 32'hee;
    #1 chk("halt_ready", 64'(in_ready), 64'h0);
    chk("halt_outA", 64'(out_data), 64'(A));
    tick(); chk("halt_outB", 64'(out_data), 64'(B));
    tick(); chk("halt_outC", 64'(out_data), 64'(C));
    tick(); chk("halt_outD", 64'(out_data), 64'(D));
    chk("halt_notdrained", 64'(drained), 64'h0);
    tick();
    chk("halt_drained", 64'(drained), 64'h1);
    chk("halt_ret", 64'(retired_cnt), 64'd18);
    in_valid = 1'b0; halt = 1'b0;
    #1 chk("unhalt_ready", 64'(in_ready), 64'h1);

    // Clamp: stall_idx=7 holds every stage.
    fill(A, B, C, D);
    stall_en = 1'b1; stall_idx = 3'd7;
    tick(); tick();
    stall_en = 1'b0; stall_idx = '0;
    chk("clamp_valid", 64'(stage_valid), 64'hf);
    chk("clamp_out", 64'(out_data), 64'(A));
    chk("clamp_ret", 64'(retired_cnt), 64'd18);
    chk("clamp_bub", 64'(bubble_cnt), 64'd2);

    // Asynchronous reset mid-cycle.
    reset = 1'b0;
    #1;
    chk("arst_valid", 64'(stage_valid), 64'h0);
    chk("arst_out", 64'(out_valid), 64'h0);
    chk("arst_ret", 64'(retired_cnt), 64'h0);
    chk("arst_bub", 64'(bubble_cnt), 64'h0);
    #1 reset = 1'b1;

    // Saturation: 20 retirements on the 4-bit-counter instance.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin in_data = 32'h100 + 32'(i); tick(); end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("sat_ret_wide", 64'(retired_cnt), 64'd20);
    chk("sat_ret_narrow", 64'(s_retired_cnt), 64'd15);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_chain.md
Name:
pipe_ctrl_chain

Overview:
- Parametrised successor to the fixed four-register pipeline backbone of the PDA core.
- Holds STAGES pipeline registers of DATA_W bits, each with a valid bit, plus per-cycle stall and flush control.
- Stall freezes stages 0..k and inserts a bubble behind them. Flush kills stages 0..f. Halt drains the pipe.
- Sits between fetch and writeback; the hazard unit and branch logic drive stall/flush; retired and bubble counters feed debug visibility.

Parameters:
- DATA_W, 32, payload width per stage.
- STAGES, 4, number of pipeline registers (2..16).
- IDX_W, 3, width of stall/flush index ports; 2^IDX_W >= STAGES.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  new payload offered to stage 0.
- in_data  in  DATA_W  payload.
- in_ready  out  1  stage 0 accepts this cycle.
- stall_en  in  1  stall request.
- stall_idx  in  IDX_W  k: highest stage held.
- flush_en  in  1  flush request.
- flush_idx  in  IDX_W  f: highest stage killed.
- halt  in  1  stop accepting input and drain.
- stage_valid  out  STAGES  valid bit per stage.
- stage_data  out  STAGES*DATA_W  stage i at [i*DATA_W +: DATA_W].
- out_valid  out  1  stage_valid[STAGES-1].
- out_data  out  DATA_W  last-stage payload.
- drained  out  1  halt asserted and pipe empty.
- retired_cnt  out  CNT_W  payloads retired.
- bubble_cnt  out  CNT_W  stall-inserted bubbles.

Behaviour:
- Reset: reset=0 asynchronously clears all valid bits, all stage data, and both counters. Takes effect immediately, mid-cycle included. Operation resumes at the first rising edge after reset=1.
- Index clamp: k = min(stall_idx, STAGES-1); f = min(flush_idx, STAGES-1).
- in_ready = !halt && !stall_en && !flush_en. Combinational.
- Per-stage update at each rising edge, evaluated in priority order:
  1. flush_en && i<=f: valid<=0, data<=0.
  2. stall_en && i<=k: hold valid and data.
  3. stall_en && i==k+1: bubble (valid<=0, data held).
  4. flush_en && i==f+1: bubble (kills wrong-path payload leaving stage f).
  5. i==0: valid<=in_valid&&in_ready; data<=in_data when accepted, else held.
  6. Otherwise: copy stage i-1 valid and data.
- Flush overrides stall on overlapping stages. Rules are evaluated independently per stage, so "flush f=0, stall k=2" kills s0, holds s1..s2, and bubbles s3.
- Latency: a payload accepted at edge n appears on out_valid after edge n+STAGES-1. Throughput is 1/cycle when no stall or flush is active.
- out_valid and out_data are direct register outputs of the last stage.
- retire event: out_valid && !(stall_en && k==STAGES-1). On each event, retired_cnt increments by 1, saturating at 2^CNT_W-1.
- bubble event: stall_en && k<STAGES-1 (counted even if stage k+1 was already invalid). On each event, bubble_cnt increments by 1, saturating. Flush bubbles are not counted.
- drained = halt && (stage_valid==0). Combinational.
- Halt does not freeze stages; the pipe keeps advancing and empties in at most STAGES cycles. Deasserting halt re-enables input on the same cycle.
- Simultaneous in_valid with stall or flush: the input is not accepted (in_ready=0), and the source must hold it.

Test Plan:
- Stream (STAGES=4): release reset, in_valid=1 with data 0x11,0x22,0x33,0x44,0x55 on consecutive edges -> out_valid first high after 4th edge with out_data=0x11, then 0x22..0x55 back-to-back; retired_cnt=5 after drain.
- Stall (pipe s0=D, s1=C, s2=B, s3=A): stall_en=1, k=1 for one edge -> s0=D, s1=C, s2 invalid, s3=B; in_ready=0 during stall; retired_cnt+1; bubble_cnt=1.
- Flush (same start): flush_en=1, f=1 -> s0, s1, s2 invalid, s3=B. Combined f=0, k=2 -> s0 invalid, s1=C, s2=B held, s3 invalid; bubble_cnt+1.
- Halt: pipe full, halt=1 -> in_ready=0, outputs A,B,C,D on 4 edges, then drained=1, retired_cnt+4; halt=0 -> in_ready=1 same cycle.
- Clamp: STAGES=4, stall_idx=7 -> all stages hold, bubble_cnt unchanged, retired_cnt unchanged, out_valid held high.
- Async reset: reset=0 mid-cycle with full pipe and counters nonzero -> stage_valid=0, out_valid=0, retired_cnt=0, bubble_cnt=0 before the next edge. Counter saturation with CNT_W=4: 20 retirements -> retired_cnt=15.
